// File: rtl/dmem_access_pkg.sv
// Shared encodings and request checking for the data-memory access unit.
package dmem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StRmwWr,
        StStore
    } state_e;

    // Flags reserved sizes, misaligned halves/words and sub-word accesses when unsupported.
    function automatic logic req_err(input logic [1:0] size, input logic [1:0] lane,
                                     input bit subword_en);
        logic err;
        err = 1'b0;
        case (size)
            SZ_BYTE: err = !subword_en;
            SZ_HALF: err = !subword_en || lane[0];
            SZ_WORD: err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module dmem_lane_align
    import dmem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, extend it, and build the read-modify-write word.
    always_comb begin
        byte_sel  = word[{lane, 3'b000} +: 8];
        half_sel  = word[{lane[1], 4'b0000} +: 16];
        load_data = word;
        merged    = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
                merged    = word;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~zero_ext & half_sel[15]}}, half_sel};
                merged    = word;
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store initiator between the MEM stage and a word-addressed data memory.
// Sub-word stores are done as read-modify-write since the memory writes whole words.
module dmem_access_unit
    import dmem_access_pkg::*;
#(
    parameter int unsigned WIDX_BITS  = 8,
    parameter bit          SUBWORD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic        mem_re
);

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        zext_q, zext_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [31:0] load_data;
    logic [31:0] merged;
    logic        unused_addr_bits;

    // Upper address bits are ignored so the address space wraps onto the memory depth.
    assign unused_addr_bits = ^req_addr[31:WIDX_BITS+2];

    dmem_lane_align u_lane_align (
        .word      (mem_rdata),
        .lane      (lane_q),
        .size      (size_q),
        .zero_ext  (zext_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Memory strobes decode from state only, so reset removes them asynchronously.
    assign req_ready  = (state_q == StIdle);
    assign mem_re     = (state_q == StLoad) || (state_q == StRmwRd);
    assign mem_we     = (state_q == StStore) || (state_q == StRmwWr);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        zext_d       = zext_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    lane_d  = req_addr[1:0];
                    size_d  = req_size;
                    zext_d  = req_unsigned;
                    wdata_d = req_wdata;
                    if (req_err(req_size, req_addr[1:0], SUBWORD_EN)) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        mem_addr_d = {{(32-WIDX_BITS){1'b0}}, req_addr[WIDX_BITS+1:2]};
                        if (!req_we) begin
                            state_d = StLoad;
                        end else if (req_size == SZ_WORD) begin
                            mem_wdata_d = req_wdata;
                            state_d     = StStore;
                        end else begin
                            state_d = StRmwRd;
                        end
                    end
                end
            end
            StLoad: begin
                resp_rdata_d = load_data;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                state_d      = StIdle;
            end
            StRmwRd: begin
                mem_wdata_d = merged;
                state_d     = StRmwWr;
            end
            StRmwWr, StStore: begin
                resp_rdata_d = '0;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            lane_q       <= '0;
            size_q       <= SZ_WORD;
            zext_q       <= 1'b0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            zext_q       <= zext_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit with a behavioural 256x32 memory.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_we;
    logic        mem_re;

    dmem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re)
    );

    always #5 clk = ~clk;

    // Memory model: write on rising edge, read captured on falling edge.
    logic [31:0] mem [256];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    always @(negedge clk) if (mem_re) mem_rdata <= mem[mem_addr[7:0]];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_re;
        int          n_we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   abort_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: tracks memory strobes per transaction and checks each response.
    initial begin : monitor
        int re_cnt;
        int we_cnt;
        exp_t e;
        re_cnt = 0;
        we_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                re_cnt = 0;
                we_cnt = 0;
            end else begin
                if ((mem_re || mem_we) && !abort_ok) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected mem access: re=%0b we=%0b expected none",
                                 mem_re, mem_we);
                    end else begin
                        if (mem_re) re_cnt++;
                        if (mem_we) we_cnt++;
                        chk("mem_addr", mem_addr, q[0].addr);
                        if (mem_we) chk("mem_wdata", mem_wdata, q[0].wdata);
                    end
                end
                if (resp_valid) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected resp_valid: got 1 expected 0");
                    end else begin
                        e = q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                        chk("latency", cyc - e.acc + 1, e.lat);
                        chk("mem_re cycles", re_cnt, e.n_re);
                        chk("mem_we cycles", we_cnt, e.n_we);
                    end
                    re_cnt = 0;
                    we_cnt = 0;
                end
            end
        end
    end

    // Drive a request, hold req_valid until accepted, then queue its expectation.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input int nre, input int nwe, input logic [31:0] exp_wdata,
                         output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept timeout: req_ready got 0 expected 1");
            req_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc     = cyc;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = lat;
            e.n_re  = nre;
            e.n_we  = nwe;
            e.addr  = {24'b0, addr[9:2]};
            e.wdata = exp_wdata;
            e.acc   = acc;
            q.push_back(e);
        end
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] exp);
        int a;
        issue(1'b0, sz, uns, addr, 32'h0, exp, 1'b0, 2, 1, 0, 32'h0, a);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_word);
        int a;
        if (sz == 2'b10) issue(1'b1, sz, 1'b0, addr, wd, 32'h0, 1'b0, 2, 0, 1, exp_word, a);
        else             issue(1'b1, sz, 1'b0, addr, wd, 32'h0, 1'b0, 3, 1, 1, exp_word, a);
    endtask

    task automatic bad(input logic we, input logic [1:0] sz, input logic [31:0] addr);
        int a;
        issue(we, sz, 1'b0, addr, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 0, 32'h0, a);
    endtask

    task automatic idle_drain();
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain timeout: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        int a1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset values while rst is held.
        @(negedge clk);
        @(negedge clk);
        chk("rst req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst mem_re", {31'b0, mem_re}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        // Word store then load.
        st(2'b10, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        ld(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

        // Sub-word store via read-modify-write.
        st(2'b10, 32'h10, 32'h1122_3344, 32'h1122_3344);
        st(2'b00, 32'h13, 32'hFFFF_FF5A, 32'h5A22_3344);
        ld(2'b10, 1'b0, 32'h10, 32'h5A22_3344);

        // Lane extraction and extension.
        st(2'b10, 32'h10, 32'h80FF_7F01, 32'h80FF_7F01);
        ld(2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
        ld(2'b00, 1'b1, 32'h13, 32'h0000_0080);
        ld(2'b01, 1'b0, 32'h12, 32'hFFFF_80FF);
        ld(2'b00, 1'b1, 32'h10, 32'h0000_0001);
        ld(2'b00, 1'b0, 32'h11, 32'h0000_007F);
        ld(2'b00, 1'b0, 32'h12, 32'hFFFF_FFFF);
        ld(2'b01, 1'b0, 32'h10, 32'h0000_7F01);
        ld(2'b01, 1'b1, 32'h12, 32'h0000_80FF);

        // Error requests: no memory access, one-cycle latency.
        bad(1'b0, 2'b10, 32'h06);
        bad(1'b1, 2'b01, 32'h11);
        bad(1'b0, 2'b11, 32'h00);
        ld(2'b10, 1'b0, 32'h10, 32'h80FF_7F01);

        // Half store into upper lane.
        st(2'b01, 32'h12, 32'h1234_BEEF, 32'hBEEF_7F01);
        ld(2'b10, 1'b0, 32'h10, 32'hBEEF_7F01);

        // Back-to-back with req_valid held; 0x400 aliases 0x000.
        issue(1'b1, 2'b10, 1'b0, 32'h000, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 0, 1,
              32'hCAFE_F00D, a0);
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1, 0, 32'h0, a1);
        chk("b2b accept spacing", a1 - a0, 2);
        idle_drain();
        chk("mem[0] via model", mem[0], 32'hCAFE_F00D);

        // Reset during RMW_WR: write must not happen, no response.
        st(2'b10, 32'h20, 32'h1122_3344, 32'h1122_3344);
        idle_drain();
        abort_ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h21;
        req_wdata = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort rmw_rd mem_re", {31'b0, mem_re}, 32'h1);
        @(negedge clk);
        chk("abort rmw_wr mem_we", {31'b0, mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort mem_we async", {31'b0, mem_we}, 32'h0);
        chk("abort mem_re async", {31'b0, mem_re}, 32'h0);
        chk("abort req_ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        chk("abort mem[8] unchanged", mem[8], 32'h1122_3344);
        rst = 1'b0;
        abort_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no resp_valid", {31'b0, resp_valid}, 32'h0);
        end
        ld(2'b10, 1'b0, 32'h20, 32'h1122_3344);
        idle_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store initiator between the pipeline MEM stage and the word-addressed 256x32 data memory.
- Accepts byte/halfword/word load and store requests from the pipeline through a valid/ready handshake, drives the memory's address, write-data, write-enable and read-enable, and returns sign- or zero-extended load data.
- Sub-word stores use read-modify-write, because the memory writes whole words only.
- Memory timing it targets: write on rising clk edge while write-enable is high; read data captured on falling clk edge while read-enable is high.

Parameters:
- WIDX_BITS, 8, word-index width presented to memory (depth = 2**WIDX_BITS words).
- SUBWORD_EN, 1, 1 = byte/half accesses supported; 0 = size!=word is flagged as an error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extend when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  misaligned or reserved-size request
- mem_addr  out  32  word index, {zeros, req_addr[WIDX_BITS+1:2]}
- mem_wdata  out  32  word to write
- mem_rdata  in  32  memory read data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable

Behaviour:
- Clocking and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- All outputs are driven from registers or decoded from the state register only; no combinational path from req_* to mem_*.
- States: IDLE, LOAD, RMW_RD, RMW_WR, STORE.
- IDLE:
  - req_ready=1. On req_valid at a rising edge, the request is latched.
  - Next state: error -> IDLE with resp_valid=1, resp_err=1 the next cycle and no memory access; load -> LOAD; word store -> STORE; sub-word store -> RMW_RD.
- Error conditions: size 11; half with addr[0]=1; word with addr[1:0]!=0; SUBWORD_EN=0 with size!=10.
- LOAD: mem_re=1 for exactly one cycle. At the closing rising edge, mem_rdata is extracted and extended into resp_rdata, resp_valid=1, state -> IDLE.
- STORE: mem_we=1 and mem_wdata=req_wdata for exactly one cycle. The memory writes at the closing edge; resp_valid=1 next cycle, state -> IDLE.
- RMW_RD: mem_re=1 for one cycle. At the closing edge, the merged word is registered into mem_wdata; state -> RMW_WR.
- RMW_WR: mem_we=1 for one cycle; state -> IDLE with resp_valid.
- Latency, accept edge to resp_valid high: load 2 cycles, word store 2, sub-word store 3, error 1.
- req_ready=0 in every state except IDLE. A request may be accepted in the same cycle resp_valid is high, so back-to-back throughput is one access per 2 cycles.
- Lanes (little-endian), lane = addr[1:0]:
  - Byte uses bits [8*lane+7:8*lane].
  - Half uses bits [16*addr[1]+15:16*addr[1]].
  - Extension uses bit 7 / bit 15 unless req_unsigned.
- Store merge replaces only the addressed byte/half lane with req_wdata[7:0] or [15:0].
- Address wrap: bits above WIDX_BITS+1 are ignored, so 0x400 aliases 0x000 (default).
- Reset mid-operation: mem_we and mem_re drop immediately (asynchronously). If rst is asserted before the RMW_WR/STORE closing edge, no write occurs. No resp_valid is issued for the aborted request.
- resp_valid is high for exactly one cycle per accepted request; resp_rdata holds its value until the next response.

Decomposition:
- Package dmem_access_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encodings;
  - error-check function.
- One combinational sub-module, dmem_lane_align: inputs word, lane, size, unsigned, wdata; outputs extended load data and merged store word. Instantiated once and shared by LOAD and RMW_RD.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_addr=0x4, mem_we one cycle, resp_rdata=0xDEADBEEF two cycles after accept.
- Memory word @0x10 = 0x11223344; byte store 0x5A @0x13 -> mem_re one cycle, then mem_we with mem_wdata=0x5A223344; resp_valid 3 cycles after accept.
- Word @0x10 = 0x80FF7F01:
  - signed byte @0x13 -> 0xFFFFFF80;
  - unsigned byte @0x13 -> 0x00000080;
  - signed half @0x12 -> 0xFFFF80FF;
  - unsigned byte @0x10 -> 0x00000001.
- Word load @0x06 and half store @0x11 -> resp_err=1, resp_valid one cycle after accept, mem_re=mem_we=0 throughout.
- Assert rst during RMW_WR before the rising edge -> mem_we falls immediately, memory word unchanged, req_ready=1, no resp_valid.
- req_valid held across completion: second request accepted on the resp_valid cycle; word load @0x400 returns the data stored @0x000.
